branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Sequencing controller for the pipelined core's dynamic branch predictor: it owns a direct-mapped table of 2-bit saturating counters indexed by PC, answers IF-stage lookups, queues in-flight B-type predictions until the EX stage resolves them, then updates the table and raises flush/redirect on a mispredict. It sits between the IF PC mux, the hazard unit (stall/flush) and the EX branch comparator, and clears the table after reset with a sequential sweep.

## Interface
- PC_SIZE, 12, width of instruction addresses
- INDEX_BITS, 6, table index width; the table holds 2^INDEX_BITS counters, indexed by pc[INDEX_BITS+1:2]
- QUEUE_DEPTH, 2, maximum unresolved B-type predictions (power of two, ≥2)
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- if_valid  in  1  IF holds a valid instruction this cycle
- if_opcode  in  7  opcode of the IF instruction (B_FORMAT / J_FORMAT from instruction_type)
- if_pc  in  PC_SIZE  PC of the IF instruction
- if_target  in  PC_SIZE  computed branch/jump target of the IF instruction
- if_next_pc  in  PC_SIZE  sequential PC (if_pc + 4)
- res_valid  in  1  EX resolves the oldest queued B-type branch this cycle
- res_taken  in  1  actual branch outcome
- pred_taken  out  1  prediction for the IF instruction
- pred_pc  out  PC_SIZE  next PC chosen by the predictor
- stall_req  out  1  IF must hold: queue full or table sweep running
- flush  out  1  mispredict detected; squash IF/ID and ID/EX
- redirect_pc  out  PC_SIZE  correct PC when flush=1
- busy  out  1  table sweep in progress
- mispredict_count  out  16  saturating mispredict counter

## Operation
- States: INIT, RUN. Reset enters INIT with sweep index 0.
- INIT: write 2'b01 (weakly not taken) to entry sweep_idx each cycle, increment; after writing entry 2^INDEX_BITS−1, go to RUN. busy=1, stall_req=1, pred_taken=0, pred_pc=if_next_pc; res_valid ignored; no pushes.
- RUN, lookup (combinational): J_FORMAT → pred_taken=1; B_FORMAT → pred_taken = counter[idx] ≥ 2; otherwise 0. pred_pc = pred_taken ? if_target : if_next_pc. Outputs are undriven-safe with if_valid=0: pred_taken=0.
- Push: if_valid & B_FORMAT & !stall_req & !flush pushes {idx, pred_taken, if_target, if_next_pc} into the FIFO. J_FORMAT is never queued.
- Resolve: res_valid with non-empty queue pops the head; counter[head.idx] += 1 if res_taken (saturate at 3), −= 1 if not (saturate at 0). Mispredict when res_taken ≠ head.pred_taken: flush=1, redirect_pc = res_taken ? head.target : head.fallthrough, mispredict_count += 1 (saturate at 16'hFFFF), and the whole queue is cleared (younger entries are wrong-path).
- res_valid with empty queue: ignored, no update, no flush.
- stall_req in RUN = queue full & if_valid & B_FORMAT & !(res_valid pop this cycle).
- Simultaneous push and pop without mispredict: both happen, occupancy unchanged. Push and mispredict pop: push suppressed, queue ends empty.
- Same-index update and lookup in one cycle: lookup sees the old counter (no bypass).

## Timing
- Reset (async, while RST_N=0): state INIT, sweep_idx=0, queue empty, mispredict_count=0; outputs busy=1, stall_req=1, flush=0, pred_taken=0, redirect_pc=0, pred_pc=if_next_pc.
- Sweep takes exactly 2^INDEX_BITS cycles after RST_N rises (64 by default); busy falls at the edge that completes the last write.
- Lookup: zero latency, same cycle as if_pc.
- flush/redirect_pc: combinational, same cycle as the res_valid that mispredicts, one cycle wide per mispredict.
- Counter update and queue pop take effect at the rising edge ending the resolve cycle.
- RST_N asserted mid-operation: queue and table sweep restart immediately; pending resolves are dropped.

## Test plan
- Reset release → busy=1 and stall_req=1 for exactly 64 cycles, then 0; every entry reads 2'b01 (B lookup pred_taken=0).
- B at pc 0x040, target 0x100, resolved taken twice → third lookup of 0x040 gives pred_taken=1, pred_pc=0x100; first resolve raised flush with redirect_pc=0x100.
- Counter at 3, resolve taken → stays 3; at 0, resolve not-taken → stays 0, no flush.
- Two B pushes (queue full), third B in IF → stall_req=1; same cycle res_valid correct → stall_req=0 and push accepted.
- Two queued, head mispredicts (pred 0, actual 1) → flush=1, redirect_pc=head target, queue empty next cycle, mispredict_count=1, simultaneous IF push dropped.
- J_FORMAT at pc 0x010, target 0x200 → pred_taken=1, pred_pc=0x200, queue occupancy unchanged; res_valid on empty queue → no flush.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor control: 2-bit counter table, in-flight B-type queue, mispredict flush/redirect.
// Lookup and flush are combinational (0 cycles); IF stalls while sweeping or when the queue is full.
module branch_predict_ctrl #(
  parameter int PC_SIZE     = 12,
  parameter int INDEX_BITS  = 6,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               if_valid,
  input  logic [6:0]         if_opcode,
  input  logic [PC_SIZE-1:0] if_pc,
  input  logic [PC_SIZE-1:0] if_target,
  input  logic [PC_SIZE-1:0] if_next_pc,
  input  logic               res_valid,
  input  logic               res_taken,
  output logic               pred_taken,
  output logic [PC_SIZE-1:0] pred_pc,
  output logic               stall_req,
  output logic               flush,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic               busy,
  output logic [15:0]        mispredict_count
);
  localparam logic [6:0] B_FORMAT = 7'b1100011;
  localparam logic [6:0] J_FORMAT = 7'b1101111;
  localparam int TBL_SIZE = 1 << INDEX_BITS;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic                  pred;
    logic [PC_SIZE-1:0]    target;
    logic [PC_SIZE-1:0]    fallthru;
  } qent_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_idx;
  logic [1:0]            ctr_tbl [TBL_SIZE];
  qent_t                 queue_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count_q;

  logic                  is_b, is_j, q_full, push, pop, mispredict;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [1:0]            head_ctr, ctr_upd;
  qent_t                 head, push_ent;
  logic                  unused_pc_bits;

  assign is_b       = (if_opcode == B_FORMAT);
  assign is_j       = (if_opcode == J_FORMAT);
  assign lookup_idx = if_pc[INDEX_BITS+1:2];
  assign q_full     = (count_q == FULL_CNT);
  assign head       = queue_q[rd_ptr];
  assign head_ctr   = ctr_tbl[head.idx];
  assign push_ent   = '{idx: lookup_idx, pred: pred_taken, target: if_target, fallthru: if_next_pc};
  assign unused_pc_bits = ^{if_pc[PC_SIZE-1:INDEX_BITS+2], if_pc[1:0]};

  always_comb begin
    ctr_upd = head_ctr;
    if (res_taken) begin
      if (head_ctr != 2'b11) ctr_upd = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) ctr_upd = head_ctr - 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    stall_req   = 1'b0;
    pred_taken  = 1'b0;
    pred_pc     = if_next_pc;
    flush       = 1'b0;
    redirect_pc = '0;
    pop         = 1'b0;
    push        = 1'b0;
    mispredict  = 1'b0;
    case (state_q)
      INIT: begin
        busy      = 1'b1;
        stall_req = 1'b1;
        if (sweep_idx == '1) state_d = RUN;
      end
      RUN: begin
        if (if_valid && is_j) pred_taken = 1'b1;
        else if (if_valid && is_b) pred_taken = ctr_tbl[lookup_idx][1];
        pred_pc    = pred_taken ? if_target : if_next_pc;
        pop        = res_valid && (count_q != '0);
        mispredict = pop && (res_taken != head.pred);
        flush      = mispredict;
        if (mispredict) redirect_pc = res_taken ? head.target : head.fallthru;
        // A same-cycle pop frees the slot, so a full queue need not stall.
        stall_req  = q_full && if_valid && is_b && !pop;
        push       = if_valid && is_b && !stall_req && !mispredict;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (state_q == INIT) ctr_tbl[sweep_idx] <= 2'b01;
    else if (pop) ctr_tbl[head.idx] <= ctr_upd;
  end

  always_ff @(posedge CLK) begin
    if (push) queue_q[wr_ptr] <= push_ent;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q          <= INIT;
      sweep_idx        <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count_q          <= '0;
      mispredict_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) sweep_idx <= sweep_idx + 1'b1;
      // Entries younger than a mispredicted branch are wrong-path: drop them all.
      if (mispredict) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
      if (mispredict && (mispredict_count != 16'hFFFF))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_branch_predict_ctrl;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        if_valid, res_valid, res_taken;
  logic [6:0]  if_opcode;
  logic [11:0] if_pc, if_target, if_next_pc;
  logic        pred_taken, stall_req, flush, busy;
  logic [11:0] pred_pc, redirect_pc;
  logic [15:0] mispredict_count;

  typedef struct packed {
    logic        pt;
    logic [11:0] ppc;
    logic        stall;
    logic        flush;
    logic [11:0] redir;
    logic        busy;
    logic [15:0] mcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e, mon_a;
  string mon_nm;
  int    n_vec = 0;
  int    n_bad = 0;

  branch_predict_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_valid(if_valid), .if_opcode(if_opcode), .if_pc(if_pc),
    .if_target(if_target), .if_next_pc(if_next_pc),
    .res_valid(res_valid), .res_taken(res_taken),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .stall_req(stall_req),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy),
    .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic v, input logic [6:0] op, input logic [11:0] pc,
                       input logic [11:0] tgt, input logic rv, input logic rt);
    @(posedge CLK);
    #1;
    if_valid   = v;
    if_opcode  = op;
    if_pc      = pc;
    if_target  = tgt;
    if_next_pc = pc + 12'd4;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  task automatic exp_out(input logic pt, input logic [11:0] ppc, input logic st, input logic fl,
                         input logic [11:0] rd, input logic bz, input logic [15:0] mc, input string nm);
    exp_t e;
    e.pt = pt; e.ppc = ppc; e.stall = st; e.flush = fl; e.redir = rd; e.busy = bz; e.mcnt = mc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Releases reset on the first vector; INIT must last exactly 64 cycles.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, OP_B, 12'(i * 4), 12'h400, 1'b1, 1'b1);
      if (i == 0) RST_N = 1'b1;
      exp_out(1'b0, 12'(i * 4 + 4), 1'b1, 1'b0, 12'h000, 1'b1, 16'd0, $sformatf("%s_busy%0d", tag, i));
    end
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b0, 1'b0);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, {tag, "_done"});
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_a  = {pred_taken, pred_pc, stall_req, flush, redirect_pc, busy, mispredict_count};
      n_vec++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got pt=%0b ppc=%h stall=%0b flush=%0b redir=%h busy=%0b mcnt=%0d, want pt=%0b ppc=%h stall=%0b flush=%0b redir=%h busy=%0b mcnt=%0d",
                 mon_nm, mon_a.pt, mon_a.ppc, mon_a.stall, mon_a.flush, mon_a.redir, mon_a.busy, mon_a.mcnt,
                 mon_e.pt, mon_e.ppc, mon_e.stall, mon_e.flush, mon_e.redir, mon_e.busy, mon_e.mcnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    if_valid = 1'b0; if_opcode = 7'd0; if_pc = '0; if_target = '0; if_next_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0;

    // Reset state, with resolves and IF activity present.
    drive(1'b1, OP_B, 12'h020, 12'h300, 1'b1, 1'b1);
    exp_out(1'b0, 12'h024, 1'b1, 1'b0, 12'h000, 1'b1, 16'd0, "reset");
    sweep_check("sweep");

    // Jump predicted taken and never queued; resolve on empty queue ignored.
    drive(1'b1, OP_J, 12'h010, 12'h200, 1'b0, 1'b0);
    exp_out(1'b1, 12'h200, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "jal");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "res_empty");

    // Fill the queue, then read every entry while stalled.
    drive(1'b1, OP_B, 12'h080, 12'h300, 1'b0, 1'b0);
    exp_out(1'b0, 12'h084, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "push_a");
    drive(1'b1, OP_B, 12'h0C0, 12'h340, 1'b0, 1'b0);
    exp_out(1'b0, 12'h0C4, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "push_b");
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, OP_B, 12'(i * 4), 12'h400, 1'b0, 1'b0);
      exp_out(1'b0, 12'(i * 4 + 4), 1'b1, 1'b0, 12'h000, 1'b0, 16'd0, $sformatf("tbl%0d", i));
    end

    // Full queue + correct resolve: no stall, push accepted, queue full again.
    drive(1'b1, OP_B, 12'h100, 12'h180, 1'b1, 1'b0);
    exp_out(1'b0, 12'h104, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "pop_push");
    drive(1'b1, OP_B, 12'h000, 12'h180, 1'b0, 1'b0);
    exp_out(1'b0, 12'h004, 1'b1, 1'b0, 12'h000, 1'b0, 16'd0, "full_again");

    // Head (pred 0) resolves taken: flush to its target, IF push dropped, queue emptied.
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b1, 1'b1);
    exp_out(1'b0, 12'h044, 1'b0, 1'b1, 12'h340, 1'b0, 16'd0, "mispredict");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "empty_after_flush");

    // Counter at 0 saturates on not-taken.
    drive(1'b1, OP_B, 12'h080, 12'h300, 1'b0, 1'b0);
    exp_out(1'b0, 12'h084, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "sat0_lk1");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b0);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "sat0_res1");
    drive(1'b1, OP_B, 12'h080, 12'h300, 1'b0, 1'b0);
    exp_out(1'b0, 12'h084, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "sat0_lk2");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b0);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "sat0_res2");

    // Train 0x040 towards taken; saturate at 3.
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b0, 12'h044, 1'b0, 1'b0, 12'h000, 1'b0, 16'd1, "train_lk1");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b1, 12'h100, 1'b0, 16'd1, "train_res1");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "train_lk2");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "train_res2");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "train_lk3");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "train_res3");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "sat3_lk");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "sat3_res");

    // Same-index update and lookup: lookup sees the old counter; flush to fall-through.
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0, 16'd2, "bypass_push");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b1, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b1, 12'h044, 1'b0, 16'd2, "bypass_same");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0, 16'd3, "ctr2_lk");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b0);
    exp_out(1'b0, 12'h004, 1'b0, 1'b1, 12'h044, 1'b0, 16'd3, "ctr2_res");
    drive(1'b1, OP_B, 12'h040, 12'h100, 1'b0, 1'b0);
    exp_out(1'b0, 12'h044, 1'b0, 1'b0, 12'h000, 1'b0, 16'd4, "ctr1_lk");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b0);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd4, "ctr1_res");

    // Reset mid-operation: queued entry and trained counter are lost.
    drive(1'b1, OP_B, 12'h0C0, 12'h340, 1'b0, 1'b0);
    exp_out(1'b1, 12'h340, 1'b0, 1'b0, 12'h000, 1'b0, 16'd4, "pre_rst");
    drive(1'b1, OP_B, 12'h0C0, 12'h340, 1'b1, 1'b0);
    RST_N = 1'b0;
    exp_out(1'b0, 12'h0C4, 1'b1, 1'b0, 12'h000, 1'b1, 16'd0, "mid_rst");
    sweep_check("resweep");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b1, 1'b1);
    exp_out(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "rst_q_empty");
    drive(1'b1, OP_B, 12'h0C0, 12'h340, 1'b0, 1'b0);
    exp_out(1'b0, 12'h0C4, 1'b0, 1'b0, 12'h000, 1'b0, 16'd0, "rst_tbl_clear");
    drive(1'b0, 7'd0, 12'h000, 12'h000, 1'b0, 1'b0);

    repeat (3) @(posedge CLK);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
